dcache_ctrl: RTL

//  Direct-mapped, write-through, no-write-allocate L1 data cache between the pipeline MEM stage and the

---
 rtl/dcache_ctrl_if.sv | 25 ++
 rtl/dcache_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU/memory bundle for the L1 data cache controller.
// slave: the cache controller; master: pipeline plus data memory.
interface dcache_ctrl_if;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  cpu_ren, cpu_wen, cpu_addr, cpu_din, mem_dout,
        output cpu_dout, cpu_stall, mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output cpu_ren, cpu_wen, cpu_addr, cpu_din, mem_dout,
        input  cpu_dout, cpu_stall, mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Read hits are served combinationally; misses and stores stall.
module dcache_ctrl #(
    parameter int LINES       = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic         clock,
    input  logic         reset,
    dcache_ctrl_if.slave bus
);
    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 32 - OB - IB;
    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    state_t           state, state_nxt;
    logic [LW-1:0]    lat_cnt, lat_nxt;
    logic [OB-1:0]    word_cnt, word_nxt;
    logic [31:0]      addr_q, data_q;
    logic [LINES-1:0] valid;
    logic [TB-1:0]    tags  [LINES];
    logic [31:0]      words [LINES][BLOCK_WORDS];

    logic [OB-1:0] cpu_off, l_off;
    logic [IB-1:0] cpu_idx, l_idx;
    logic [TB-1:0] cpu_tag, l_tag;
    logic          cpu_hit, l_hit, lat_last, word_last;
    logic          start_miss, start_write;

    assign cpu_off   = bus.cpu_addr[OB-1:0];
    assign cpu_idx   = bus.cpu_addr[OB+IB-1:OB];
    assign cpu_tag   = bus.cpu_addr[31:OB+IB];
    assign l_off     = addr_q[OB-1:0];
    assign l_idx     = addr_q[OB+IB-1:OB];
    assign l_tag     = addr_q[31:OB+IB];
    assign cpu_hit   = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
    assign l_hit     = valid[l_idx] && (tags[l_idx] == l_tag);
    assign lat_last  = (lat_cnt == LW'(MEM_LATENCY - 1));
    assign word_last = (word_cnt == OB'(BLOCK_WORDS - 1));

    always_comb begin
        state_nxt     = state;
        lat_nxt       = lat_cnt;
        word_nxt      = word_cnt;
        start_miss    = 1'b0;
        start_write   = 1'b0;
        bus.cpu_dout  = '0;
        bus.cpu_stall = 1'b0;
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_din   = '0;
        unique case (state)
            IDLE: begin
                if (bus.cpu_wen) begin
                    bus.cpu_stall = 1'b1;
                    start_write   = 1'b1;
                    lat_nxt       = '0;
                    state_nxt     = WRITE;
                end else if (bus.cpu_ren) begin
                    if (cpu_hit) begin
                        bus.cpu_dout = words[cpu_idx][cpu_off];
                    end else begin
                        bus.cpu_stall = 1'b1;
                        start_miss    = 1'b1;
                        lat_nxt       = '0;
                        word_nxt      = '0;
                        state_nxt     = REFILL;
                    end
                end
            end
            REFILL: begin
                bus.cpu_stall = 1'b1;
                bus.mem_ren   = 1'b1;
                bus.mem_addr  = {addr_q[31:OB], word_cnt};
                if (lat_last) begin
                    lat_nxt  = '0;
                    word_nxt = word_cnt + OB'(1);
                    if (word_last) state_nxt = IDLE;
                end else begin
                    lat_nxt = lat_cnt + LW'(1);
                end
            end
            WRITE: begin
                bus.cpu_stall = 1'b1;
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_din   = data_q;
                if (lat_last) begin
                    lat_nxt   = '0;
                    state_nxt = WDONE;
                end else begin
                    lat_nxt = lat_cnt + LW'(1);
                end
            end
            WDONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // a request held across reset must not freeze the pipeline
        if (!reset) bus.cpu_stall = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            word_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            valid    <= '0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            word_cnt <= word_nxt;
            if (start_write) begin
                addr_q <= bus.cpu_addr;
                data_q <= bus.cpu_din;
            end
            if (start_miss) begin
                addr_q         <= bus.cpu_addr;
                valid[cpu_idx] <= 1'b0;
            end
            if (state == REFILL && lat_last && word_last) valid[l_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate them.
    always_ff @(posedge clock) begin
        if (state == REFILL && lat_last) begin
            words[l_idx][word_cnt] <= bus.mem_dout;
            if (word_last) tags[l_idx] <= l_tag;
        end
        if (state == WRITE && lat_last && l_hit) words[l_idx][l_off] <= data_q;
    end
endmodule
